// File: rtl/rr_arbiter8.sv
// rr_arbiter8 -- 8-way round-robin arbiter with grant hold.
// The registered gnt_idx/gnt_vld outputs feed a 3-to-8 decoder (Din/en);
// gnt is the same grant in one-hot form. Every grant is followed by one
// bubble cycle, and the pointer moves past the released owner.
// Optional feature: define ARB_TIMEOUT_EN to force a release after
// MAX_HOLD cycles of continuous ownership (pulses timeout).
module rr_arbiter8 #(
    parameter int N_REQ    = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             rel,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             timeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic [N_REQ-1:0]   gnt_nxt;
    logic               vld_nxt;
    logic               to_nxt;

    logic [IDX_W-1:0]   sel_idx;
    logic               sel_found;
    logic [IDX_W-1:0]   cand;
    logic [N_REQ-1:0]   sel_oh;

    logic               rel_cond;
    logic               force_rel;

    // Rotating priority scan: the first set req bit starting at ptr wins.
    // Scanning k downwards lets the smallest offset overwrite last.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // One-hot form of the selected index.
    for (genvar g = 0; g < N_REQ; g++) begin : g_oh
        assign sel_oh[g] = (sel_idx == IDX_W'(g));
    end

    // Voluntary release: owner pulses rel, drops its request, or arbiter disabled.
    assign rel_cond = rel | ~req[gnt_idx] | ~en;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    logic [CNT_W-1:0] hold_cnt;

    // A forced release only fires when nothing else is releasing, so a
    // coincident rel is reported as a normal release (timeout stays 0).
    assign force_rel = (state == BUSY) && !rel_cond &&
                       (hold_cnt == CNT_W'(MAX_HOLD - 1));

    // Hold counter: zero while idle, counts held cycles, saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold_cnt <= '0;
        else if (state != BUSY)
            hold_cnt <= '0;
        else if (!rel_cond && !force_rel && (hold_cnt != {CNT_W{1'b1}}))
            hold_cnt <= hold_cnt + 1'b1;
    end
`else
    // No hold limit: the comparison is always false for a legal MAX_HOLD.
    assign force_rel = (MAX_HOLD < 0);
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = gnt_idx;
        gnt_nxt   = gnt;
        vld_nxt   = gnt_vld;
        to_nxt    = 1'b0;
        case (state)
            IDLE: begin
                gnt_nxt = '0;
                vld_nxt = 1'b0;
                if (en && sel_found) begin
                    state_nxt = BUSY;
                    idx_nxt   = sel_idx;
                    gnt_nxt   = sel_oh;
                    vld_nxt   = 1'b1;
                end
            end
            BUSY: begin
                if (rel_cond || force_rel) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    vld_nxt   = 1'b0;
                    ptr_nxt   = gnt_idx + 1'b1;
                    to_nxt    = force_rel;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                vld_nxt   = 1'b0;
            end
        endcase
    end

    // State, pointer and registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt     <= '0;
            gnt_idx <= '0;
            gnt_vld <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            gnt     <= gnt_nxt;
            gnt_idx <= idx_nxt;
            gnt_vld <= vld_nxt;
            timeout <= to_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios plus random traffic, checked by
// a scoreboard fed from an integer-level model of the arbitration rules.
module tb_rr_arbiter8;

    localparam int MAXH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       rel = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    rr_arbiter8 #(.N_REQ(8), .IDX_W(3), .MAX_HOLD(MAXH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .rel(rel),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
        logic       to;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model state: owner -1 means nobody holds the resource.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_last  = 0;
    int m_held  = 0;
    bit m_to    = 0;
    bit prev_rst_n = 0;

    // Apply one cycle of inputs, advance the model by one edge, queue the result.
    task automatic step(input bit r_n, input bit e, input logic [7:0] rq, input bit rl);
        exp_t x;
        bit   rel_c;
        bit   forced;
        @(negedge clk);
        rst_n = r_n; en = e; req = rq; rel = rl;
        if (!r_n) begin
            m_owner = -1; m_ptr = 0; m_last = 0; m_held = 0; m_to = 0;
            if (prev_rst_n) begin
                #1;
                checks++;
                if (gnt !== 8'h00 || gnt_vld !== 1'b0 || timeout !== 1'b0) begin
                    failures++;
                    $display("FAIL async_reset: gnt=%h vld=%b to=%b, want gnt=00 vld=0 to=0",
                             gnt, gnt_vld, timeout);
                end
            end
        end else begin
            m_to = 0;
            if (m_owner < 0) begin
                if (e && rq != 8'h00) begin
                    for (int k = 0; k < 8; k++) begin
                        if (m_owner < 0 && rq[(m_ptr + k) % 8]) begin
                            m_owner = (m_ptr + k) % 8;
                        end
                    end
                    m_last = m_owner;
                    m_held = 0;
                end
            end else begin
                rel_c = rl || !rq[m_owner] || !e;
`ifdef ARB_TIMEOUT_EN
                forced = !rel_c && (m_held == MAXH - 1);
`else
                forced = 0;
`endif
                if (rel_c || forced) begin
                    m_ptr   = (m_owner + 1) % 8;
                    m_owner = -1;
                    m_to    = forced;
                end else if (m_held < 1000) begin
                    m_held++;
                end
            end
        end
        prev_rst_n = r_n;
        x.gnt = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        x.idx = 3'(m_last);
        x.vld = (m_owner >= 0);
        x.to  = m_to;
        q.push_back(x);
    endtask

    // Monitor: after each edge, pop the expected outputs and compare.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_vld !== e.vld || timeout !== e.to) begin
                    failures++;
                    $display("FAIL grant@%0t: got gnt=%h idx=%0d vld=%b to=%b, want gnt=%h idx=%0d vld=%b to=%b",
                             $time, gnt, gnt_idx, gnt_vld, timeout, e.gnt, e.idx, e.vld, e.to);
                end
            end
        end
    end

    initial begin : stim
        logic [7:0] rq;
        bit         e, rl, rn;
        // Reset state.
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);

        // Single request: held until rel, then a bubble; rel in idle ignored.
        step(1, 1, 8'h08, 0);
        repeat (3) step(1, 1, 8'h08, 0);
        step(1, 1, 8'h08, 1);
        step(1, 1, 8'h00, 1);
        step(1, 1, 8'h00, 0);

        // Reset mid-grant with owner 5, then first grant scans from 0.
        step(1, 1, 8'h20, 0);
        step(1, 1, 8'h20, 0);
        step(0, 1, 8'h20, 0);
        step(1, 1, 8'h21, 0);
        step(1, 1, 8'h21, 1);
        step(1, 1, 8'h00, 0);

        // Round robin across all requesters.
        step(0, 0, 8'h00, 0);
        for (int i = 0; i < 9; i++) begin
            step(1, 1, 8'hFF, 0);
            step(1, 1, 8'hFF, 1);
        end
        step(1, 1, 8'h00, 0);

        // Wrap: grant 6, then 0x41 picks 0, then 0x41 picks 6.
        step(0, 0, 8'h00, 0);
        step(1, 1, 8'h40, 0);
        step(1, 1, 8'h40, 1);
        step(1, 1, 8'h41, 0);
        step(1, 1, 8'h41, 1);
        step(1, 1, 8'h41, 0);
        step(1, 1, 8'h41, 1);
        step(1, 1, 8'h00, 0);

        // Request drop, then enable gating.
        step(0, 0, 8'h00, 0);
        step(1, 1, 8'h04, 0);
        step(1, 1, 8'h04, 0);
        step(1, 1, 8'h00, 0);
        repeat (3) step(1, 0, 8'h04, 0);
        step(1, 1, 8'h04, 0);
        step(1, 1, 8'h04, 0);
        step(1, 0, 8'h04, 0);
        step(1, 1, 8'h00, 0);

        // Long hold (timeout when enabled, indefinite otherwise).
        step(0, 0, 8'h00, 0);
        repeat (20) step(1, 1, 8'h03, 0);
        step(1, 1, 8'h00, 0);

        // Random traffic with sticky requests and rare resets.
        rq = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) rq = rq ^ 8'($urandom_range(0, 255));
            e  = ($urandom_range(0, 9) != 0);
            rl = ($urandom_range(0, 3) == 0);
            rn = ($urandom_range(0, 299) != 0);
            step(rn, e, rq, rl);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected results left, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
